// File: rtl/core_sequencer_pkg.sv
// Shared types and constants for the multi-cycle core sequencer.
package core_sequencer_pkg;

    localparam logic [6:0] OPC_LOAD    = 7'b000_0011;
    localparam logic [6:0] OPC_LOAD_FP = 7'b000_0111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WB,
        S_FAULT
    } seq_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE        = 2'd0,
        CAUSE_MISALIGNED  = 2'd1,
        CAUSE_BUS_TIMEOUT = 2'd2
    } fault_cause_t;

    // LUI also raises mem2reg in this decoder, so the opcode must qualify it.
    function automatic logic is_load(input logic mem2reg, input logic [6:0] opc);
        return mem2reg && (opc == OPC_LOAD || opc == OPC_LOAD_FP);
    endfunction

endpackage

// File: rtl/core_sequencer_mem_wait_timer.sv
// Wait counter for a pending memory request; expire flags the cycle that would reach MEM_TIMEOUT.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CW'(1);
        end
    end

    assign expire = inc && (count == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer owning pc, instr and instret.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    input  logic [6:0]  opcode,
    input  logic        ctrl_mem_write,
    input  logic        ctrl_mem2reg,
    input  logic        ctrl_reg_write,
    input  logic        ctrl_is_branch,
    input  logic        ctrl_is_jump,
    input  logic        ctrl_branch_taken,
    input  logic [31:0] branch_target,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic        retire,
    output logic [63:0] instret,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    seq_state_t   state;
    fault_cause_t cause;
    logic         lat_taken;
    logic         lat_reg_write;
    logic [31:0]  lat_target;
    logic         timer_clr;
    logic         timer_inc;
    logic         timer_expire;
    logic         exec_taken;
    logic         exec_misaligned;
    logic         exec_mem;

    assign imem_addr       = pc;
    assign fault_cause     = cause;
    assign exec_taken      = ctrl_is_jump | (ctrl_is_branch & ctrl_branch_taken);
    assign exec_misaligned = exec_taken && (branch_target[1:0] != 2'b00);
    assign exec_mem        = ctrl_mem_write || is_load(ctrl_mem2reg, opcode);

    // Counter sits at zero outside the two wait states, so entry always starts from zero.
    assign timer_clr = (state != S_FETCH) && (state != S_MEM);
    assign timer_inc = (state == S_FETCH && !imem_ack) || (state == S_MEM && !dmem_ack);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (timer_clr),
        .inc    (timer_inc),
        .expire (timer_expire)
    );

    // Outputs are registered: each transition sets the outputs of the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            pc            <= RESET_PC;
            instr         <= '0;
            instret       <= '0;
            cause         <= CAUSE_NONE;
            fault         <= 1'b0;
            imem_req      <= 1'b0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            rf_we         <= 1'b0;
            retire        <= 1'b0;
            lat_taken     <= 1'b0;
            lat_reg_write <= 1'b0;
            lat_target    <= '0;
        end else begin
            rf_we  <= 1'b0;
            retire <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        instr    <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end else if (timer_expire) begin
                        imem_req <= 1'b0;
                        fault    <= 1'b1;
                        cause    <= CAUSE_BUS_TIMEOUT;
                        state    <= S_FAULT;
                    end
                end
                S_DECODE: begin
                    state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    lat_taken     <= exec_taken;
                    lat_reg_write <= ctrl_reg_write;
                    lat_target    <= branch_target;
                    if (exec_misaligned) begin
                        fault <= 1'b1;
                        cause <= CAUSE_MISALIGNED;
                        state <= S_FAULT;
                    end else if (exec_mem) begin
                        dmem_req <= 1'b1;
                        dmem_we  <= ctrl_mem_write;
                        state    <= S_MEM;
                    end else begin
                        rf_we  <= ctrl_reg_write;
                        retire <= 1'b1;
                        state  <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        rf_we    <= lat_reg_write;
                        retire   <= 1'b1;
                        state    <= S_WB;
                    end else if (timer_expire) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        fault    <= 1'b1;
                        cause    <= CAUSE_BUS_TIMEOUT;
                        state    <= S_FAULT;
                    end
                end
                S_WB: begin
                    pc      <= lat_taken ? lat_target : pc + 32'd4;
                    instret <= instret + 64'd1;
                    if (run) begin
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized self-checking bench for core_sequencer against an instruction-level timing model.
module tb_core_sequencer;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam int          MEM_TIMEOUT = 16;
    localparam logic [6:0]  OP_ALU      = 7'b0110011;
    localparam logic [6:0]  OP_LUI      = 7'b0110111;
    localparam logic [6:0]  OP_LOAD     = 7'b0000011;
    localparam logic [6:0]  OP_LOAD_FP  = 7'b0000111;
    localparam logic [6:0]  OP_STORE    = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH   = 7'b1100011;
    localparam logic [6:0]  OP_JAL      = 7'b1101111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic        ctrl_mem_write, ctrl_mem2reg, ctrl_reg_write;
    logic        ctrl_is_branch, ctrl_is_jump, ctrl_branch_taken;
    logic [31:0] branch_target;
    logic        dmem_req, dmem_we, dmem_ack;
    logic        rf_we;
    logic [31:0] pc;
    logic        retire;
    logic [63:0] instret;
    logic        fault;
    logic [1:0]  fault_cause;

    int          checks;
    int          errors;
    logic [31:0] model_pc;
    logic [63:0] model_instret;

    always #5 clk = ~clk;

    core_sequencer #(
        .RESET_PC    (RESET_PC),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .run               (run),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ack          (imem_ack),
        .imem_rdata        (imem_rdata),
        .instr             (instr),
        .opcode            (opcode),
        .ctrl_mem_write    (ctrl_mem_write),
        .ctrl_mem2reg      (ctrl_mem2reg),
        .ctrl_reg_write    (ctrl_reg_write),
        .ctrl_is_branch    (ctrl_is_branch),
        .ctrl_is_jump      (ctrl_is_jump),
        .ctrl_branch_taken (ctrl_branch_taken),
        .branch_target     (branch_target),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_ack          (dmem_ack),
        .rf_we             (rf_we),
        .pc                (pc),
        .retire            (retire),
        .instret           (instret),
        .fault             (fault),
        .fault_cause       (fault_cause)
    );

    task automatic set_ctrl(input logic [6:0] opc, input logic mw, input logic m2r,
                            input logic rw, input logic isb, input logic isj,
                            input logic tk, input logic [31:0] tgt);
        opcode            = opc;
        ctrl_mem_write    = mw;
        ctrl_mem2reg      = m2r;
        ctrl_reg_write    = rw;
        ctrl_is_branch    = isb;
        ctrl_is_jump      = isj;
        ctrl_branch_taken = tk;
        branch_target     = tgt;
    endtask

    task automatic apply_reset(input logic run_val);
        @(negedge clk);
        rst_n    = 1'b0;
        run      = run_val;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n         = 1'b1;
        model_pc      = RESET_PC;
        model_instret = 64'd0;
    endtask

    // Runs one instruction end to end; expectations come from the instruction-level model.
    task automatic do_instr(input logic [31:0] word, input logic [6:0] opc,
                            input logic mw, input logic m2r, input logic rw,
                            input logic isb, input logic isj, input logic tk,
                            input logic [31:0] tgt, input int ilat, input int dlat,
                            input int drop_at, input bit noise);
        int   cyc, iwait, dwait, dbeats, addr_bad, we_bad, exp_cyc, exp_beats, ret_cyc;
        bit   is_mem, taken, done;
        logic rf_seen;
        is_mem    = mw || (m2r && (opc == OP_LOAD || opc == OP_LOAD_FP));
        taken     = isj || (isb && tk);
        exp_beats = is_mem ? dlat + 1 : 0;
        exp_cyc   = 4 + ilat + exp_beats;
        set_ctrl(opc, mw, m2r, rw, isb, isj, tk, tgt);
        imem_rdata = word;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (imem_req) break;
        end
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL fetch_start imem_req=%0b want 1", imem_req);
            return;
        end
        cyc = 1; iwait = 0; dwait = 0; dbeats = 0; addr_bad = 0; we_bad = 0;
        done = 0; ret_cyc = 0; rf_seen = 1'b0;
        while (!done && cyc <= 100) begin
            if (imem_req) begin
                if (imem_addr !== model_pc) addr_bad++;
                imem_ack = (iwait == ilat);
                iwait++;
            end else begin
                imem_ack = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
            if (dmem_req) begin
                dbeats++;
                if (dmem_we !== mw) we_bad++;
                dmem_ack = (dwait == dlat);
                dwait++;
            end else begin
                dmem_ack = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
            if (cyc == drop_at) run = 1'b0;
            if (retire === 1'b1) begin
                done    = 1;
                ret_cyc = cyc;
                rf_seen = rf_we;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL retire_timeout no retire within %0d cycles want cycle %0d", cyc, exp_cyc);
            return;
        end
        checks++;
        if (ret_cyc != exp_cyc) begin
            errors++;
            $display("FAIL latency opc=%h retire cycle %0d want %0d", opc, ret_cyc, exp_cyc);
        end
        checks++;
        if (rf_seen !== rw) begin
            errors++;
            $display("FAIL rf_we opc=%h got %0b want %0b", opc, rf_seen, rw);
        end
        checks++;
        if (addr_bad != 0) begin
            errors++;
            $display("FAIL imem_addr %0d fetch cycles off want pc %h", addr_bad, model_pc);
        end
        checks++;
        if (dbeats != exp_beats || we_bad != 0) begin
            errors++;
            $display("FAIL dmem opc=%h beats %0d bad_we %0d want beats %0d we %0b",
                     opc, dbeats, we_bad, exp_beats, mw);
        end
        checks++;
        if (instr !== word) begin
            errors++;
            $display("FAIL instr got %h want %h", instr, word);
        end
        model_pc      = taken ? tgt : model_pc + 32'd4;
        model_instret = model_instret + 64'd1;
        @(posedge clk);
        #1;
        checks++;
        if (pc !== model_pc || instret !== model_instret || fault !== 1'b0) begin
            errors++;
            $display("FAIL wb_update pc %h instret %0d fault %0b want pc %h instret %0d fault 0",
                     pc, instret, fault, model_pc, model_instret);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        run   = 1'b0;
        #3;
        checks++;
        if (pc !== RESET_PC || instr !== 32'd0 || instret !== 64'd0 || fault_cause !== 2'd0) begin
            errors++;
            $display("FAIL reset_regs pc %h instr %h instret %0d cause %0d want %h 0 0 0",
                     pc, instr, instret, fault_cause, RESET_PC);
        end
        checks++;
        if ({imem_req, dmem_req, dmem_we, rf_we, retire, fault} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outs req/we/rf/ret/fault=%b want 000000",
                     {imem_req, dmem_req, dmem_we, rf_we, retire, fault});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_run imem_req=%0b want 0", imem_req);
        end
    endtask

    task automatic test_alu_branch();
        apply_reset(1'b1);
        do_instr(32'h0020_81B3, OP_ALU, 0, 0, 1, 0, 0, 0, 32'h0, 0, 0, -1, 0);
        do_instr(32'h0E00_0063, OP_BRANCH, 0, 0, 0, 1, 0, 1, 32'h0000_0100, 0, 0, -1, 0);
        do_instr(32'h0040_0113, OP_ALU, 0, 0, 1, 0, 0, 0, 32'h0, 1, 0, -1, 0);
        do_instr(32'h0000_0063, OP_BRANCH, 0, 0, 0, 1, 0, 0, 32'h0000_0200, 0, 0, -1, 0);
    endtask

    task automatic test_load_delay();
        do_instr(32'h0000_2083, OP_LOAD, 0, 1, 1, 0, 0, 0, 32'h0, 0, 3, -1, 0);
        do_instr(32'h0000_2087, OP_LOAD_FP, 0, 1, 1, 0, 0, 0, 32'h0, 2, 0, -1, 0);
        do_instr(32'h1234_50B7, OP_LUI, 0, 1, 1, 0, 0, 0, 32'h0, 0, 0, -1, 0);
    endtask

    task automatic test_ack_boundary();
        do_instr(32'h0010_0093, OP_ALU, 0, 0, 1, 0, 0, 0, 32'h0, MEM_TIMEOUT - 1, 0, -1, 0);
        do_instr(32'h0011_2023, OP_STORE, 1, 0, 0, 0, 0, 0, 32'h0, 0, MEM_TIMEOUT - 1, -1, 0);
    endtask

    task automatic test_run_drop();
        int reqs;
        do_instr(32'h0011_2223, OP_STORE, 1, 0, 0, 0, 0, 0, 32'h0, 0, 3, 5, 0);
        reqs = 0;
        repeat (8) begin
            @(negedge clk);
            if (imem_req !== 1'b0 || dmem_req !== 1'b0) reqs++;
        end
        checks++;
        if (reqs != 0) begin
            errors++;
            $display("FAIL run_drop_park %0d cycles with a request want 0", reqs);
        end
        run = 1'b1;
        do_instr(32'h0030_0193, OP_ALU, 0, 0, 1, 0, 0, 0, 32'h0, 0, 0, -1, 0);
    endtask

    task automatic test_back_to_back_random();
        logic [31:0] word, tgt;
        logic        tk, m2r;
        int          kind, ilat, dlat;
        for (int n = 0; n < 40; n++) begin
            word = $urandom();
            tgt  = $urandom() & 32'hFFFF_FFFC;
            tk   = 1'($urandom_range(0, 1));
            m2r  = 1'($urandom_range(0, 1));
            ilat = $urandom_range(0, 4);
            dlat = $urandom_range(0, 4);
            kind = $urandom_range(0, 5);
            case (kind)
                0: do_instr(word, OP_ALU, 0, 0, 1, 0, 0, 0, tgt, ilat, dlat, -1, 1);
                1: do_instr(word, OP_LUI, 0, m2r, 1, 0, 0, 0, tgt, ilat, dlat, -1, 1);
                2: do_instr(word, tk ? OP_LOAD : OP_LOAD_FP, 0, 1, 1, 0, 0, 0, tgt, ilat, dlat, -1, 1);
                3: do_instr(word, OP_STORE, 1, 0, 0, 0, 0, 0, tgt, ilat, dlat, -1, 1);
                4: do_instr(word, OP_BRANCH, 0, 0, 0, 1, 0, tk, tgt, ilat, dlat, -1, 1);
                default: do_instr(word, OP_JAL, 0, 0, 1, 0, 1, 1, tgt, ilat, dlat, -1, 1);
            endcase
        end
    endtask

    task automatic test_misaligned();
        int bad;
        apply_reset(1'b1);
        set_ctrl(OP_JAL, 0, 0, 1, 0, 1, 1, 32'h0000_0102);
        imem_rdata = 32'h1020_006F;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (imem_req) break;
        end
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_early fault=%0b in execute want 0", fault);
        end
        @(negedge clk);
        checks++;
        if (fault !== 1'b1 || fault_cause !== 2'd1) begin
            errors++;
            $display("FAIL misaligned_cause fault %0b cause %0d want 1 1", fault, fault_cause);
        end
        bad = 0;
        repeat (20) begin
            if (retire || rf_we || imem_req || dmem_req || !fault || pc !== RESET_PC || instret !== 64'd0)
                bad++;
            imem_ack = 1'($urandom_range(0, 1));
            dmem_ack = 1'($urandom_range(0, 1));
            run      = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL misaligned_sticky %0d bad cycles want 0 (pc %h)", bad, pc);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (fault !== 1'b0 || fault_cause !== 2'd0 || pc !== RESET_PC) begin
            errors++;
            $display("FAIL async_reset fault %0b cause %0d pc %h want 0 0 %h",
                     fault, fault_cause, pc, RESET_PC);
        end
    endtask

    task automatic test_timeout();
        int  reqs;
        bit  seen;
        apply_reset(1'b1);
        reqs = 0;
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (imem_req) begin
                reqs++;
                seen = 1;
            end else if (seen) begin
                break;
            end
        end
        checks++;
        if (reqs != MEM_TIMEOUT) begin
            errors++;
            $display("FAIL imem_timeout req cycles %0d want %0d", reqs, MEM_TIMEOUT);
        end
        checks++;
        if (fault !== 1'b1 || fault_cause !== 2'd2 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL imem_timeout_cause fault %0b cause %0d req %0b want 1 2 0",
                     fault, fault_cause, imem_req);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (fault !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_timeout fault %0b req %0b want 0 0", fault, imem_req);
        end
    endtask

    task automatic test_dmem_timeout();
        int reqs, rets;
        bit seen;
        apply_reset(1'b1);
        set_ctrl(OP_STORE, 1, 0, 0, 0, 0, 0, 32'h0);
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (imem_req) break;
        end
        imem_ack = 1'b1;
        reqs = 0;
        rets = 0;
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            imem_ack = 1'b0;
            if (retire) rets++;
            if (dmem_req) begin
                reqs++;
                seen = 1;
            end else if (seen) begin
                break;
            end
        end
        checks++;
        if (reqs != MEM_TIMEOUT || rets != 0) begin
            errors++;
            $display("FAIL dmem_timeout req cycles %0d retires %0d want %0d 0", reqs, rets, MEM_TIMEOUT);
        end
        checks++;
        if (fault !== 1'b1 || fault_cause !== 2'd2) begin
            errors++;
            $display("FAIL dmem_timeout_cause fault %0b cause %0d want 1 2", fault, fault_cause);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        imem_ack   = 1'b0;
        dmem_ack   = 1'b0;
        imem_rdata = 32'h0;
        set_ctrl(OP_ALU, 0, 0, 0, 0, 0, 0, 32'h0);
        model_pc      = RESET_PC;
        model_instret = 64'd0;
        test_reset();
        test_alu_branch();
        test_load_delay();
        test_ack_boundary();
        test_run_drop();
        test_back_to_back_random();
        test_misaligned();
        test_timeout();
        test_dmem_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle sequencer for the RV32 core. It steps one instruction at a time through FETCH, DECODE, EXECUTE, optional MEM and WB. It owns the PC, the instruction register and the retired-instruction counter, and it handshakes with instruction and data memory. It consumes the per-instruction control signals from `control_unit` and turns them into single-cycle enables for the register file and data memory.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value loaded at reset.
- `MEM_TIMEOUT`, 16: maximum number of cycles a memory request may wait for ack before a fault is raised.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `run` in 1: allows new fetches.
- `imem_req` out 1 / `imem_addr` out 32 / `imem_ack` in 1 / `imem_rdata` in 32: instruction fetch handshake.
- `instr` out 32: instruction register, feeds the decoder.
- `opcode` in 7: decoded opcode of `instr`.
- `ctrl_mem_write`, `ctrl_mem2reg`, `ctrl_reg_write`, `ctrl_is_branch`, `ctrl_is_jump`, `ctrl_branch_taken` in 1 each: from `control_unit`.
- `branch_target` in 32: target address computed by the datapath.
- `dmem_req` out 1 / `dmem_we` out 1 / `dmem_ack` in 1: data memory handshake.
- `rf_we` out 1: register-file write enable, one-cycle pulse.
- `pc` out 32: current PC.
- `retire` out 1: one-cycle pulse per completed instruction.
- `instret` out 64: retired-instruction count.
- `fault` out 1 / `fault_cause` out 2: sticky fault flag and its cause.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WB, FAULT.
- Reset values: state IDLE, `pc`=`RESET_PC`, `instr`=0, `instret`=0, `fault_cause`=NONE. All other outputs are 0.
- IDLE → FETCH when `run`=1.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`, held stable until ack.
  - On `imem_ack`, `instr` ← `imem_rdata`, then go to DECODE.
- DECODE: one cycle for the decoder and `control_unit` to settle. Go to EXECUTE.
- EXECUTE: latch all `ctrl_*` signals and `branch_target`.
  - If the instruction is a load or store, go to MEM. Load means `ctrl_mem2reg`=1 and `opcode` is LOAD or LOAD_FP. Store means `ctrl_mem_write`=1.
  - All other instructions go to WB. `ctrl_mem2reg` on LUI does not cause a memory access.
- MEM:
  - `dmem_req`=1 and `dmem_we`=latched `ctrl_mem_write`, held until `dmem_ack`.
  - On ack, go to WB.
- WB:
  - `rf_we`=latched `ctrl_reg_write`, `retire`=1, `instret`+=1. `instret` wraps modulo 2^64.
  - PC update: `pc` ← latched target if latched taken=1, otherwise `pc`+4 (modulo 2^32).
  - Next state: FETCH if `run`=1, else IDLE.
- Misaligned target: if the latched taken flag is 1 and target[1:0]≠0, the FSM goes from EXECUTE to FAULT with cause MISALIGNED. The PC is not updated, there is no retire, and `rf_we` stays 0.
- Timeout:
  - A wait counter clears on entering FETCH or MEM and increments every cycle the request is held without ack.
  - If it reaches `MEM_TIMEOUT`, the FSM goes to FAULT with cause BUS_TIMEOUT, and `imem_req`/`dmem_req` drop in the next cycle.
  - If ack and timeout occur in the same cycle, the ack wins.
- FAULT: sticky, with `fault`=1. Leaving it requires `rst_n`.
- Dropping `run` mid-instruction does not abort. The current instruction completes and the FSM parks in IDLE.

## Timing
- With zero-wait memory (ack in the same cycle as req):
  - ALU, branch and jump instructions take 4 cycles from FETCH entry to WB.
  - Loads and stores take 5 cycles.
- Each cycle of ack delay adds one cycle.
- `rf_we`, `retire`, the `pc` update and the `instret` increment all take effect in the same WB cycle. `pc` and `instret` are registered and change at the end of WB.
- `imem_addr` equals `pc` throughout FETCH.
- An ack received outside the matching request state is ignored.
- Asserting `rst_n`=0 in any state drops all requests and enables asynchronously. On release, the FSM enters IDLE.

## Structure
- The shared `common` package gains:
  - `seq_state_t`, an enum for the seven states.
  - `fault_cause_t`: NONE=0, MISALIGNED=1, BUS_TIMEOUT=2.
- The existing LOAD/LOAD_FP opcode constants are reused from `common`.
- One sub-module, `mem_wait_timer`: a counter with clear and increment inputs and a `MEM_TIMEOUT` compare, shared by FETCH and MEM.

## Test plan
- Reset with `run`=1 and zero-wait imem returning an ADD (`ctrl_reg_write`=1) → `imem_addr`=0x0. `rf_we` pulses in cycle 4. `pc`=0x4 and `instret`=1 afterwards.
- Taken branch with `branch_target`=0x100 → WB produces `rf_we`=0, `pc`=0x100, and the next `imem_addr`=0x100.
- Load with `dmem_ack` delayed 3 cycles → `dmem_req` is held for 4 cycles with `dmem_we`=0. The instruction retires in cycle 8 with `rf_we`=1.
- Taken jump to 0x102 → FAULT with `fault_cause`=1. `pc` is unchanged, there is no retire, and the FSM stays in FAULT until reset.
- `imem_ack` never asserted with `MEM_TIMEOUT`=16 → `fault`=1 and cause=2 after 16 wait cycles, then `imem_req`=0.
- `run` dropped during MEM of a store → the store completes and retires, then the FSM goes to IDLE with no further `imem_req`. Reasserting `run` resumes fetching at `pc`+4.
